// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler and long-latency scoreboard.
// Pipeline writeback always wins the single write port; a one-entry hold buffer
// parks a long-latency result that lost arbitration, and a starvation counter
// asks upstream for a writeback bubble when that entry waits too long.
module regfile_wb_scheduler #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    output logic        id_stall,
    output logic        wb_stall_req,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data
);

    localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);

    logic [31:0] busy_q, busy_d;
    logic        hold_valid_q, hold_valid_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        stall_req_q, stall_req_d;
    logic        we_q, we_d;
    logic [4:0]  wr_q, wr_d;
    logic [31:0] wd_q, wd_d;
    // Pending scoreboard clear for the long-latency write currently on the port
    logic        clr_valid_q, clr_valid_d;
    logic [4:0]  clr_rd_q, clr_rd_d;

    logic        lu_xfer;
    logic        grant;
    logic        grant_lu;
    logic        lost;

    assign lu_ready     = ~hold_valid_q;
    assign issue_ready  = ~busy_q[issue_rd];
    assign wb_stall_req = stall_req_q;
    assign RegWrite     = we_q;
    assign Write_register = wr_q;
    assign Write_data   = wd_q;

    // busy_q[0] is held at zero, so the rd != 0 terms are implicit
    assign id_stall = busy_q[id_rs] | busy_q[id_rt] | busy_q[id_rd];

    // Write-port arbitration: pipeline first, then hold entry, then a direct
    // long-latency bypass when the hold entry is empty and the port is idle.
    always_comb begin
        lu_xfer      = lu_valid & ~hold_valid_q;
        grant        = 1'b0;
        grant_lu     = 1'b0;
        wr_d         = wr_q;
        wd_d         = wd_q;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        if (wb_valid) begin
            grant = 1'b1;
            wr_d  = wb_rd;
            wd_d  = wb_data;
            if (lu_xfer) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = lu_rd;
                hold_data_d  = lu_data;
            end
        end else if (hold_valid_q) begin
            grant        = 1'b1;
            grant_lu     = 1'b1;
            wr_d         = hold_rd_q;
            wd_d         = hold_data_q;
            hold_valid_d = 1'b0;
        end else if (lu_xfer) begin
            grant    = 1'b1;
            grant_lu = 1'b1;
            wr_d     = lu_rd;
            wd_d     = lu_data;
        end
        we_d        = grant & (wr_d != 5'd0);
        clr_valid_d = grant_lu & (wr_d != 5'd0);
        clr_rd_d    = wr_d;
    end

    // Starvation counter: counts cycles the hold entry is valid but loses the port
    always_comb begin
        lost = hold_valid_q & wb_valid;
        if (lost) begin
            wait_cnt_d  = (wait_cnt_q == 4'hf) ? wait_cnt_q : wait_cnt_q + 4'd1;
            stall_req_d = stall_req_q | (wait_cnt_q == WaitLast);
        end else begin
            wait_cnt_d  = 4'd0;
            stall_req_d = 1'b0;
        end
    end

    // Scoreboard: clear lands with the register-file write, set on dispatch
    always_comb begin
        busy_d = busy_q;
        if (clr_valid_q) begin
            busy_d[clr_rd_q] = 1'b0;
        end
        if (issue_valid && issue_ready && issue_rd != 5'd0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State and registered write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            wait_cnt_q   <= '0;
            stall_req_q  <= 1'b0;
            we_q         <= 1'b0;
            wr_q         <= '0;
            wd_q         <= '0;
            clr_valid_q  <= 1'b0;
            clr_rd_q     <= '0;
        end else begin
            busy_q       <= busy_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_req_q  <= stall_req_d;
            we_q         <= we_d;
            wr_q         <= wr_d;
            wd_q         <= wd_d;
            clr_valid_q  <= clr_valid_d;
            clr_rd_q     <= clr_rd_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios followed by
// random traffic, all checked against a behavioural model of the write port.
module tb_regfile_wb_scheduler;

    localparam int MaxWait = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_stall;
    logic        wb_stall_req;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;

    int passed = 0;
    int total  = 0;

    regfile_wb_scheduler #(.MAX_WAIT(MaxWait)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_rd          (lu_rd),
        .lu_data        (lu_data),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_ready    (issue_ready),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_stall       (id_stall),
        .wb_stall_req   (wb_stall_req),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data)
    );

    always #5 clk = ~clk;

    // Reference model: set of outstanding registers, a queue for the parked
    // result, a count of lost cycles, and the last write presented to the file.
    bit          m_busy[32];
    logic [36:0] m_hold[$];
    int          m_lost;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    int          m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_hold.delete();
        m_lost  = 0;
        m_stall = 1'b0;
        m_we    = 1'b0;
        m_wr    = '0;
        m_wd    = '0;
        m_pend  = -1;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit          had;
        bit          take;
        bit          issue_ok;
        int          new_pend;
        logic [36:0] e;
        if (rst) begin
            model_reset();
            return;
        end
        had      = (m_hold.size() != 0);
        take     = lu_valid && !had;
        new_pend = -1;
        issue_ok = issue_valid && !m_busy[issue_rd] && (issue_rd != 0);
        if (wb_valid) begin
            m_we = (wb_rd != 0); m_wr = wb_rd; m_wd = wb_data;
            if (take) m_hold.push_back({lu_rd, lu_data});
        end else if (had) begin
            e = m_hold.pop_front();
            m_we = (e[36:32] != 0); m_wr = e[36:32]; m_wd = e[31:0];
            new_pend = int'(e[36:32]);
        end else if (take) begin
            m_we = (lu_rd != 0); m_wr = lu_rd; m_wd = lu_data;
            new_pend = int'(lu_rd);
        end else begin
            m_we = 1'b0;
        end
        if (m_pend > 0) m_busy[m_pend] = 1'b0;
        if (issue_ok) m_busy[issue_rd] = 1'b1;
        m_pend = new_pend;
        if (had && wb_valid) begin
            if (m_lost == MaxWait - 1) m_stall = 1'b1;
            m_lost++;
        end else begin
            m_lost  = 0;
            m_stall = 1'b0;
        end
    endfunction

    task automatic check_comb();
        chk("lu_ready", lu_ready, (m_hold.size() == 0));
        chk("issue_ready", issue_ready, !m_busy[issue_rd]);
        chk("id_stall", id_stall, m_busy[id_rs] || m_busy[id_rt] || m_busy[id_rd]);
    endtask

    task automatic check_reg();
        chk("RegWrite", RegWrite, m_we);
        chk("Write_register", Write_register, m_wr);
        chk("Write_data", Write_data, m_wd);
        chk("wb_stall_req", wb_stall_req, m_stall);
    endtask

    // One cycle: check combinational outputs, clock, then check registered ones.
    task automatic step();
        #1;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_reg();
    endtask

    task automatic idle();
        rst = 1'b0; wb_valid = 1'b0; lu_valid = 1'b0; issue_valid = 1'b0;
        wb_rd = '0; wb_data = '0; lu_rd = '0; lu_data = '0; issue_rd = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
    endtask

    initial begin
        model_reset();
        idle();
        @(posedge clk);
        #1;

        // Reset for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1;
            wb_valid = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
            lu_valid = 1'($urandom); lu_rd = 5'($urandom); lu_data = $urandom;
            issue_valid = 1'($urandom); issue_rd = 5'($urandom);
            model_step();
            @(posedge clk);
            #1;
        end
        idle();
        id_rs = 5'd7;
        #1;
        check_reg();
        check_comb();
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_lu_ready", lu_ready, 1'b1);
        chk("rst_id_stall", id_stall, 1'b0);

        // Pipeline writeback, then a write to r0
        idle(); wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        chk("wb_we", RegWrite, 1'b1);
        chk("wb_wr", Write_register, 5'd5);
        chk("wb_wd", Write_data, 32'hDEADBEEF);
        idle(); wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        step();
        chk("wb_r0_we", RegWrite, 1'b0);

        // Scoreboard: issue r8, result returns with idle writeback
        idle(); issue_valid = 1'b1; issue_rd = 5'd8;
        step();
        idle(); issue_rd = 5'd8; id_rs = 5'd8;
        #1;
        chk("sb_issue_ready", issue_ready, 1'b0);
        chk("sb_stall", id_stall, 1'b1);
        lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h12;
        step();
        chk("sb_lu_we", RegWrite, 1'b1);
        chk("sb_lu_wr", Write_register, 5'd8);
        chk("sb_stall_m1", id_stall, 1'b1);
        idle(); id_rs = 5'd8;
        step();
        chk("sb_stall_m2", id_stall, 1'b0);

        // Contention: r9 parked behind continuous writeback (r3)
        idle(); issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        idle(); wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99; id_rt = 5'd9;
        step();
        chk("ct_wr3", Write_register, 5'd3);
        lu_valid = 1'b0;
        for (int i = 0; i < MaxWait; i++) begin
            chk("ct_no_req", wb_stall_req, 1'b0);
            chk("ct_lu_ready", lu_ready, 1'b0);
            step();
        end
        chk("ct_req", wb_stall_req, 1'b1);
        chk("ct_busy9", id_stall, 1'b1);
        idle(); id_rt = 5'd9;
        step();
        chk("ct_drain_wr", Write_register, 5'd9);
        chk("ct_drain_wd", Write_data, 32'h99);
        chk("ct_req_fall", wb_stall_req, 1'b0);
        chk("ct_busy9_hold", id_stall, 1'b1);
        step();
        chk("ct_busy9_clr", id_stall, 1'b0);

        // Mid-operation reset with r12 outstanding and parked
        idle(); issue_valid = 1'b1; issue_rd = 5'd12;
        step();
        idle(); wb_valid = 1'b1; wb_rd = 5'd4; lu_valid = 1'b1; lu_rd = 5'd12;
        lu_data = 32'hC;
        step();
        idle(); rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd6; issue_valid = 1'b1;
        issue_rd = 5'd13;
        step();
        idle(); id_rs = 5'd12;
        step();
        chk("mr_no_write", RegWrite, 1'b0);
        chk("mr_busy12", id_stall, 1'b0);
        chk("mr_lu_ready", lu_ready, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(63) == 0);
            wb_valid = wb_stall_req ? ($urandom_range(3) == 0) : 1'($urandom);
            wb_rd = 5'($urandom); wb_data = $urandom;
            lu_valid = 1'($urandom); lu_rd = 5'($urandom_range(15)); lu_data = $urandom;
            issue_valid = 1'($urandom); issue_rd = 5'($urandom_range(15));
            id_rs = 5'($urandom_range(15)); id_rt = 5'($urandom_range(15));
            id_rd = 5'($urandom_range(15));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
